// File: rtl/dls_pkg.sv
// dls_pkg -- shared types and constants for the dual-lockstep fault manager.
//   dls_state_t    : fault FSM state, also reported in STATUS[2:1]
//   *_OFF          : register word index, compared against HADDR[3:2]
//   *_BIT / *_LSB  : field positions inside STATUS / CTRL / CLEAR
//   dls_dp_t       : captured AHB address phase, consumed in the data phase
package dls_pkg;

  typedef enum logic [1:0] {
    DLS_OK      = 2'd0,
    DLS_SUSPECT = 2'd1,
    DLS_FAULT   = 2'd2
  } dls_state_t;

  // Register word indices (byte offsets 0x0/0x4/0x8/0xC)
  localparam logic [1:0] DLS_STATUS_OFF = 2'd0;
  localparam logic [1:0] DLS_COUNT_OFF  = 2'd1;
  localparam logic [1:0] DLS_CTRL_OFF   = 2'd2;
  localparam logic [1:0] DLS_CLEAR_OFF  = 2'd3;

  // STATUS fields
  localparam int DLS_STAT_FAULT_BIT = 0;
  localparam int DLS_STAT_STATE_LSB = 1;

  // CTRL fields
  localparam int         DLS_CTRL_IRQ_EN_BIT   = 0;
  localparam int         DLS_CTRL_BLANK_EN_BIT = 1;
  localparam logic [1:0] DLS_CTRL_RST          = 2'b11;

  // CLEAR fields
  localparam int DLS_CLR_FAULT_BIT = 0;
  localparam int DLS_CLR_COUNT_BIT = 1;

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [1:0] addr;
  } dls_dp_t;

endpackage

// File: rtl/dls_ahb_regs.sv
// dls_ahb_regs -- AHB-Lite slave front end of the fault manager.
//   HCLK/HRESETn           : clock, async active-low reset
//   HSEL..HWDATA           : AHB-Lite slave inputs
//   HRDATA/HREADYOUT       : read data (valid in read data phase, else 0), always ready
//   state/count            : live status from the core, shown in STATUS/COUNT
//   irq_en/blank_en        : CTRL register bits
//   clr_fault/clr_count    : one-cycle CLEAR pulses, valid during the write data
//                            phase so the core acts on them at the commit edge
module dls_ahb_regs
  import dls_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic             HREADY,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  input  dls_state_t       state,
  input  logic [CNT_W-1:0] count,
  output logic             irq_en,
  output logic             blank_en,
  output logic             clr_fault,
  output logic             clr_count
);

  dls_dp_t    dp;
  logic [1:0] ctrl_q;
  logic       wr_commit;

  // Only NONSEQ/SEQ (HTRANS[1]) start a transfer; word index is HADDR[3:2].
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dp <= '0;
    else          dp <= '{vld: HSEL & HREADY & HTRANS[1], wr: HWRITE, addr: HADDR[3:2]};
  end

  assign wr_commit = dp.vld & dp.wr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                                  ctrl_q <= DLS_CTRL_RST;
    else if (wr_commit && dp.addr == DLS_CTRL_OFF) ctrl_q <= HWDATA[1:0];
  end

  // CLEAR has no storage: the pulse only exists for the commit cycle.
  assign clr_fault = wr_commit && (dp.addr == DLS_CLEAR_OFF) && HWDATA[DLS_CLR_FAULT_BIT];
  assign clr_count = wr_commit && (dp.addr == DLS_CLEAR_OFF) && HWDATA[DLS_CLR_COUNT_BIT];

  assign irq_en    = ctrl_q[DLS_CTRL_IRQ_EN_BIT];
  assign blank_en  = ctrl_q[DLS_CTRL_BLANK_EN_BIT];
  assign HREADYOUT = 1'b1;

  always_comb begin
    HRDATA = '0;
    if (dp.vld && !dp.wr) begin
      case (dp.addr)
        DLS_STATUS_OFF: begin
          HRDATA[DLS_STAT_FAULT_BIT]      = (state == DLS_FAULT);
          HRDATA[DLS_STAT_STATE_LSB +: 2] = state;
        end
        DLS_COUNT_OFF: HRDATA = 32'(count);
        DLS_CTRL_OFF:  HRDATA[1:0] = ctrl_q;
        default:       HRDATA = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:2]};

endmodule

// File: rtl/dls_fault_manager.sv
// dls_fault_manager -- downstream stage of the dual-lockstep VGA pair.
// Filters transient DLS_ERROR mismatches, latches persistent faults, counts
// mismatch cycles, and blanks RGB while a fault is latched.
//   HCLK/HRESETn              : clock, async active-low reset
//   HSEL..HREADYOUT           : AHB-Lite slave (STATUS/COUNT/CTRL/CLEAR)
//   DLS_ERROR                 : comparator mismatch flag
//   RGB_IN/HSYNC_IN/VSYNC_IN  : primary VGA outputs
//   RGB_OUT/HSYNC_OUT/VSYNC_OUT : protected VGA outputs, 1-cycle registered
//   FAULT_IRQ                 : level interrupt, FAULT & irq_en
module dls_fault_manager
  import dls_pkg::*;
#(
  parameter int FILTER_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        DLS_ERROR,
  input  logic [7:0]  RGB_IN,
  input  logic        HSYNC_IN,
  input  logic        VSYNC_IN,
  output logic [7:0]  RGB_OUT,
  output logic        HSYNC_OUT,
  output logic        VSYNC_OUT,
  output logic        FAULT_IRQ
);

  localparam logic [8:0]       FC9     = 9'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  dls_state_t       state_q, state_nxt;
  logic [7:0]       run_q, run_nxt;
  logic [8:0]       run_inc;
  logic [CNT_W-1:0] cnt_q;
  logic             irq_en, blank_en, clr_fault, clr_count;
  logic             in_fault;

  dls_ahb_regs #(.CNT_W(CNT_W)) u_regs (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .state     (state_q),
    .count     (cnt_q),
    .irq_en    (irq_en),
    .blank_en  (blank_en),
    .clr_fault (clr_fault),
    .clr_count (clr_count)
  );

  assign in_fault = (state_q == DLS_FAULT);

  // 9-bit increment so the compare against FILTER_CYCLES=255 cannot wrap.
  assign run_inc = {1'b0, run_q} + 9'd1;

  always_comb begin
    state_nxt = state_q;
    run_nxt   = run_q;
    case (state_q)
      DLS_OK: begin
        if (DLS_ERROR) begin
          run_nxt   = 8'd1;
          state_nxt = (FC9 == 9'd1) ? DLS_FAULT : DLS_SUSPECT;
        end
      end
      DLS_SUSPECT: begin
        if (!DLS_ERROR) begin
          state_nxt = DLS_OK;
          run_nxt   = 8'd0;
        end else begin
          run_nxt = run_inc[7:0];
          if (run_inc >= FC9) state_nxt = DLS_FAULT;
        end
      end
      DLS_FAULT: begin
        // Sticky; a clear with the error still present re-enters the filter.
        if (clr_fault) begin
          state_nxt = DLS_ERROR ? DLS_SUSPECT : DLS_OK;
          run_nxt   = DLS_ERROR ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_nxt = DLS_OK;
        run_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DLS_OK;
      run_q   <= 8'd0;
    end else begin
      state_q <= state_nxt;
      run_q   <= run_nxt;
    end
  end

  // Mismatch counter: saturating, clear wins over a coincident increment.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                         cnt_q <= '0;
    else if (clr_count)                   cnt_q <= '0;
    else if (DLS_ERROR && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
  end

  // Video path: all three signals share one register stage to stay aligned.
  // Syncs are never gated so the monitor keeps lock during a fault.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      RGB_OUT   <= 8'h00;
      HSYNC_OUT <= 1'b1;
      VSYNC_OUT <= 1'b1;
    end else begin
      RGB_OUT   <= (in_fault && blank_en) ? 8'h00 : RGB_IN;
      HSYNC_OUT <= HSYNC_IN;
      VSYNC_OUT <= VSYNC_IN;
    end
  end

  assign FAULT_IRQ = in_fault & irq_en;

endmodule

// File: tb/tb_dls_fault_manager.sv
// Randomized + directed bench for dls_fault_manager. The reference model
// tracks the consecutive-error streak, a sticky fault flag, a saturating count
// and the CTRL bits, and predicts every output after each clock edge.
module tb_dls_fault_manager;

  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        DLS_ERROR, HSYNC_IN, VSYNC_IN, HSYNC_OUT, VSYNC_OUT, FAULT_IRQ;
  logic [7:0]  RGB_IN, RGB_OUT;

  dls_fault_manager #(.FILTER_CYCLES(FC), .CNT_W(CW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .DLS_ERROR(DLS_ERROR), .RGB_IN(RGB_IN),
    .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN), .RGB_OUT(RGB_OUT),
    .HSYNC_OUT(HSYNC_OUT), .VSYNC_OUT(VSYNC_OUT), .FAULT_IRQ(FAULT_IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int       m_streak;   // consecutive error cycles seen (reset by clear/no-error)
  bit       m_fault;
  int       m_count;
  bit [1:0] m_ctrl;
  bit       m_dp_v, m_dp_w;
  bit [1:0] m_dp_a;
  bit [7:0] m_rgb;
  bit       m_hs, m_vs;

  task automatic model_reset();
    m_streak = 0; m_fault = 0; m_count = 0; m_ctrl = 2'b11;
    m_dp_v = 0; m_dp_w = 0; m_dp_a = 0;
    m_rgb = 8'h00; m_hs = 1; m_vs = 1;
  endtask

  function automatic logic [31:0] model_read(input bit [1:0] a);
    case (a)
      2'd0:    return m_fault ? 32'h5 : (m_streak > 0 ? 32'h2 : 32'h0);
      2'd1:    return 32'(m_count);
      2'd2:    return {30'h0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare all outputs 1 time unit later.
  task automatic step();
    bit cf, cc;
    cf = 0; cc = 0;
    @(posedge HCLK);
    if (HRESETn) begin
      if (m_dp_v && m_dp_w && m_dp_a == 2'd3) begin
        cf = HWDATA[0];
        cc = HWDATA[1];
      end
      m_rgb = (m_fault && m_ctrl[1]) ? 8'h00 : RGB_IN;
      m_hs  = HSYNC_IN;
      m_vs  = VSYNC_IN;
      if (m_fault && cf) begin
        m_fault  = 0;
        m_streak = DLS_ERROR ? 1 : 0;
      end else if (DLS_ERROR) begin
        m_streak++;
        if (m_streak >= FC) m_fault = 1;
      end else begin
        m_streak = 0;
      end
      if (cc)                           m_count = 0;
      else if (DLS_ERROR && m_count < CMAX) m_count++;
      if (m_dp_v && m_dp_w && m_dp_a == 2'd2) m_ctrl = HWDATA[1:0];
      m_dp_v = HSEL && HREADY && HTRANS[1];
      m_dp_w = HWRITE;
      m_dp_a = HADDR[3:2];
    end
    #1;
    if (HRESETn) begin
      chk("irq", FAULT_IRQ, m_fault & m_ctrl[0]);
      chk("rgb", RGB_OUT, m_rgb);
      chk("hsync", HSYNC_OUT, m_hs);
      chk("vsync", VSYNC_OUT, m_vs);
      chk("hreadyout", HREADYOUT, 1'b1);
      if (m_dp_v && !m_dp_w) chk("hrdata", HRDATA, model_read(m_dp_a));
    end else begin
      chk("rst_rgb", RGB_OUT, 8'h00);
      chk("rst_hsync", HSYNC_OUT, 1'b1);
      chk("rst_vsync", VSYNC_OUT, 1'b1);
      chk("rst_irq", FAULT_IRQ, 1'b0);
      chk("rst_hrdata", HRDATA, 32'h0);
    end
  endtask

  // Drive the bus for one cycle: an address phase (sel/wr/a) plus the write
  // data belonging to the previous address phase.
  task automatic bus(input bit sel, input bit wr, input bit [1:0] a, input bit [31:0] wd);
    HSEL   = sel;
    HTRANS = sel ? 2'b10 : 2'b00;
    HWRITE = wr;
    HADDR  = {28'h0, a, 2'b00};
    HWDATA = wd;
    HREADY = 1'b1;
  endtask

  task automatic wr(input bit [1:0] a, input bit [31:0] d);
    bus(1, 1, a, 0);
    step();
    bus(0, 0, 0, d);
    step();
  endtask

  task automatic rd(input bit [1:0] a, output logic [31:0] d);
    bus(1, 0, a, 0);
    step();
    d = HRDATA;
    bus(0, 0, 0, 0);
    step();
  endtask

  logic [31:0] d;

  initial begin
    HRESETn = 0; DLS_ERROR = 0; RGB_IN = 8'h11; HSYNC_IN = 0; VSYNC_IN = 0;
    bus(0, 0, 0, 0);
    model_reset();
    repeat (3) step();
    @(negedge HCLK) HRESETn = 1;

    // Reset values over the bus
    rd(2'd0, d); chk("reset_status", d, 32'h0);
    rd(2'd1, d); chk("reset_count", d, 32'h0);
    rd(2'd2, d); chk("reset_ctrl", d, 32'h3);

    // One-cycle glitch: filtered, but counted
    HSYNC_IN = 1; VSYNC_IN = 1; RGB_IN = 8'h3C;
    DLS_ERROR = 1; step();
    DLS_ERROR = 0; step(); step();
    chk("glitch_irq", FAULT_IRQ, 1'b0);
    chk("glitch_rgb", RGB_OUT, 8'h3C);
    rd(2'd0, d); chk("glitch_status", d, 32'h0);
    rd(2'd1, d); chk("glitch_count", d, 32'h1);

    // Persistent fault
    wr(2'd3, 32'h2);
    RGB_IN = 8'hA5;
    DLS_ERROR = 1; HSYNC_IN = 0; step();
    chk("fault_irq_early", FAULT_IRQ, 1'b0);
    HSYNC_IN = 1; step();
    chk("fault_irq_rise", FAULT_IRQ, 1'b1);
    chk("fault_rgb_pre", RGB_OUT, 8'hA5);
    HSYNC_IN = 0; step();
    chk("fault_rgb_blank", RGB_OUT, 8'h00);
    chk("fault_hsync_follow", HSYNC_OUT, 1'b0);
    DLS_ERROR = 0;
    rd(2'd1, d); chk("fault_count", d, 32'h3);
    rd(2'd0, d); chk("fault_status", d, 32'h5);

    // Clear while the error is still present -> SUSPECT, then FAULT again
    DLS_ERROR = 1;
    bus(1, 1, 2'd3, 0); step();
    bus(1, 0, 2'd0, 32'h1); step();
    chk("clr_err_status", HRDATA, 32'h2);
    chk("clr_err_irq", FAULT_IRQ, 1'b0);
    bus(0, 0, 0, 0); step();
    chk("clr_err_refault", FAULT_IRQ, 1'b1);
    DLS_ERROR = 0;

    // Mask controls during FAULT
    wr(2'd2, 32'h0);
    chk("mask_irq", FAULT_IRQ, 1'b0);
    RGB_IN = 8'h5A; step();
    chk("mask_rgb", RGB_OUT, 8'h5A);
    rd(2'd0, d); chk("mask_status", d, 32'h5);
    wr(2'd2, 32'h3);
    chk("unmask_irq", FAULT_IRQ, 1'b1);

    // Saturation and clear-wins
    wr(2'd3, 32'h2);
    DLS_ERROR = 1; repeat (20) step();
    DLS_ERROR = 0;
    rd(2'd1, d); chk("sat_count", d, 32'hF);
    DLS_ERROR = 1;
    bus(1, 1, 2'd3, 0); step();
    bus(1, 0, 2'd1, 32'h2); step();
    chk("clr_cnt_wins", HRDATA, 32'h0);
    DLS_ERROR = 0;
    bus(0, 0, 0, 0); step();

    // Asynchronous reset mid-fault
    chk("pre_reset_irq", FAULT_IRQ, 1'b1);
    @(posedge HCLK); #3 HRESETn = 0; #1;
    chk("async_irq", FAULT_IRQ, 1'b0);
    chk("async_rgb", RGB_OUT, 8'h00);
    chk("async_hsync", HSYNC_OUT, 1'b1);
    chk("async_vsync", VSYNC_OUT, 1'b1);
    model_reset();
    step();
    @(negedge HCLK) HRESETn = 1;
    rd(2'd0, d); chk("post_reset_status", d, 32'h0);
    rd(2'd1, d); chk("post_reset_count", d, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 4) == 0) DLS_ERROR = ~DLS_ERROR;
      RGB_IN   = 8'($urandom);
      HSYNC_IN = 1'($urandom);
      VSYNC_IN = 1'($urandom);
      HSEL     = 1'($urandom);
      HTRANS   = 2'($urandom);
      HWRITE   = 1'($urandom);
      HADDR    = $urandom;
      HWDATA   = $urandom;
      HREADY   = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
